// File: rtl/diff_pair_sampler.sv
// -----------------------------------------------------------------------------
// diff_pair_sampler
//
// Receive stage behind a complementary-output differential input buffer.
// Both buffer rails are resynchronised into the clk domain. The stage checks
// that the two rails are complementary and debounces the received level. It
// then presents a qualified level with one-cycle edge strobes. A run of
// non-complementary samples (open, shorted or unterminated input) is reported
// as a fault episode and counted.
//
// Parameters
//   SYNC_STAGES  synchroniser depth per rail (2..4)
//   FILTER_LEN   identical valid samples needed to qualify a level, and
//                invalid samples needed to declare a fault (1..15)
//   CNT_WIDTH    width of the fault episode counter
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high reset
//   o_in         true rail from the buffer (asynchronous)
//   ob_in        complement rail from the buffer (asynchronous)
//   clr_fault    synchronous clear of fault and fault_count
//   data_out     qualified received level
//   rise         one-cycle strobe on a data_out 0->1 change
//   fall         one-cycle strobe on a data_out 1->0 change
//   valid        data_out currently holds a qualified level
//   fault        sticky: a fault episode occurred since the last clear
//   fault_count  number of fault episodes, saturating at all-ones
// -----------------------------------------------------------------------------
module diff_pair_sampler #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 4,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 o_in,
   input  logic                 ob_in,
   input  logic                 clr_fault,
   output logic                 data_out,
   output logic                 rise,
   output logic                 fall,
   output logic                 valid,
   output logic                 fault,
   output logic [CNT_WIDTH-1:0] fault_count
);

   localparam logic [3:0] FL = 4'(FILTER_LEN);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_LOCKED = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

   // ---------------------------------------------------------------------------
   // Synchronisers. The o chain resets to 0 and the ob chain resets to 1, so
   // reset presents a valid "0" pair downstream and never an invalid one.
   // ---------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] o_sync;
   logic [SYNC_STAGES-1:0] ob_sync;
   logic                   s_o;
   logic                   s_ob;

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         o_sync  <= '0;
         ob_sync <= '1;
      end else begin
         o_sync  <= {o_sync[SYNC_STAGES-2:0], o_in};
         ob_sync <= {ob_sync[SYNC_STAGES-2:0], ob_in};
      end
   end

   assign s_o  = o_sync[SYNC_STAGES-1];
   assign s_ob = ob_sync[SYNC_STAGES-1];

   // ---------------------------------------------------------------------------
   // Pair classification and glitch filter
   // ---------------------------------------------------------------------------
   logic       samp_valid;
   logic       samp_level;
   logic       cand, cand_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [3:0] icnt, icnt_nxt;
   logic       qualify;
   logic       fault_hit;

   assign samp_valid = s_o ^ s_ob;
   assign samp_level = s_o;

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      cand_nxt = cand;
      cnt_nxt  = cnt;
      icnt_nxt = icnt;
      if (samp_valid) begin
         icnt_nxt = '0;
         if (samp_level == cand) begin
            if (cnt != FL) cnt_nxt = cnt + 4'd1;
         end else begin
            cand_nxt = samp_level;
            cnt_nxt  = 4'd1;
         end
      end else begin
         cnt_nxt = '0;
         if (icnt != FL) icnt_nxt = icnt + 4'd1;
      end
   end

   // Both decisions use the post-edge counter values, so the edge on which a
   // count reaches FILTER_LEN is itself the qualifying (or faulting) edge.
   assign qualify   = samp_valid && (cnt_nxt == FL);
   assign fault_hit = !samp_valid && (icnt_nxt == FL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cand <= 1'b0;
         cnt  <= '0;
         icnt <= '0;
      end else begin
         cand <= cand_nxt;
         cnt  <= cnt_nxt;
         icnt <= icnt_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Level state machine
   // ---------------------------------------------------------------------------
   state_t state, state_nxt;
   logic   data_nxt;
   logic   rise_nxt;
   logic   fall_nxt;
   logic   enter_fault;

   always_comb begin
      state_nxt   = state;
      data_nxt    = data_out;
      rise_nxt    = 1'b0;
      fall_nxt    = 1'b0;
      enter_fault = 1'b0;
      unique case (state)
         ST_INIT: begin
            // First lock after reset: adopt the level silently.
            if (qualify) begin
               state_nxt = ST_LOCKED;
               data_nxt  = cand_nxt;
            end else if (fault_hit) begin
               state_nxt   = ST_FAULT;
               enter_fault = 1'b1;
            end
         end
         ST_LOCKED, ST_FAULT: begin
            // Strobes compare against the held level, so recovering from a
            // fault at the same level it had before emits nothing.
            if (qualify) begin
               state_nxt = ST_LOCKED;
               data_nxt  = cand_nxt;
               rise_nxt  = cand_nxt & ~data_out;
               fall_nxt  = ~cand_nxt & data_out;
            end else if (fault_hit && (state == ST_LOCKED)) begin
               state_nxt   = ST_FAULT;
               enter_fault = 1'b1;
            end
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_INIT;
         data_out <= 1'b0;
         rise     <= 1'b0;
         fall     <= 1'b0;
         valid    <= 1'b0;
      end else begin
         state    <= state_nxt;
         data_out <= data_nxt;
         rise     <= rise_nxt;
         fall     <= fall_nxt;
         valid    <= (state_nxt == ST_LOCKED);
      end
   end

   // ---------------------------------------------------------------------------
   // Fault accounting. A clear on the same edge as a fault entry wins, and
   // that entry is not counted.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fault       <= 1'b0;
         fault_count <= '0;
      end else if (clr_fault) begin
         fault       <= 1'b0;
         fault_count <= '0;
      end else if (enter_fault) begin
         fault <= 1'b1;
         if (fault_count != '1) fault_count <= fault_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_diff_pair_sampler.sv
// -----------------------------------------------------------------------------
// tb_diff_pair_sampler
//
// Self-checking bench for diff_pair_sampler with default parameters
// (SYNC_STAGES=2, FILTER_LEN=4, CNT_WIDTH=8). A table of input phases
// covers glitch rejection, fault entry and recovery, and clearing. Hand-written
// sequences cover exact latency, a clear that coincides with a fault entry,
// counter saturation, and a reset asserted mid-acquisition.
// -----------------------------------------------------------------------------
module tb_diff_pair_sampler;

   logic       clk = 1'b0;
   logic       reset;
   logic       o_in;
   logic       ob_in;
   logic       clr_fault;
   logic       data_out;
   logic       rise;
   logic       fall;
   logic       valid;
   logic       fault;
   logic [7:0] fault_count;

   diff_pair_sampler #(
      .SYNC_STAGES(2),
      .FILTER_LEN (4),
      .CNT_WIDTH  (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .o_in       (o_in),
      .ob_in      (ob_in),
      .clr_fault  (clr_fault),
      .data_out   (data_out),
      .rise       (rise),
      .fall       (fall),
      .valid      (valid),
      .fault      (fault),
      .fault_count(fault_count)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int n_rise  = 0;
   int n_fall  = 0;
   int n_both  = 0;

   typedef struct {
      logic       o;
      logic       ob;
      logic       clr;
      int         ncyc;
      logic       exp_data;
      logic       exp_valid;
      logic       exp_fault;
      logic [7:0] exp_count;
      int         exp_rise;
      int         exp_fall;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Advance one rising edge and sample 1 time unit after it; strobes are
   // tallied so a phase can check how many pulses it produced.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rise === 1'b1) n_rise++;
      if (fall === 1'b1) n_fall++;
      if (rise === 1'b1 && fall === 1'b1) n_both++;
   endtask

   task automatic drive(input logic o, input logic ob);
      o_in  = o;
      ob_in = ob;
   endtask

   task automatic clear_strobe_counts();
      n_rise = 0;
      n_fall = 0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_data"},  data_out,    0);
      check({tag, "_rise"},  rise,        0);
      check({tag, "_fall"},  fall,        0);
      check({tag, "_valid"}, valid,       0);
      check({tag, "_fault"}, fault,       0);
      check({tag, "_count"}, fault_count, 0);
   endtask

   // Watchdog: every wait below is a fixed cycle count, this only guards
   // against a simulator-level stall.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Phases start in LOCKED at level 0, fault clear, count 0.
      vecs[0] = '{1'b1, 1'b0, 1'b0,  3, 1'b0, 1'b1, 1'b0, 8'd0, 0, 0}; // short 1 pulse
      vecs[1] = '{1'b0, 1'b1, 1'b0,  8, 1'b0, 1'b1, 1'b0, 8'd0, 0, 0};
      vecs[2] = '{1'b1, 1'b1, 1'b0,  3, 1'b0, 1'b1, 1'b0, 8'd0, 0, 0}; // short invalid
      vecs[3] = '{1'b0, 1'b1, 1'b0,  8, 1'b0, 1'b1, 1'b0, 8'd0, 0, 0};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b1, 8'd1, 0, 0}; // fault 1
      vecs[5] = '{1'b1, 1'b0, 1'b0,  8, 1'b1, 1'b1, 1'b1, 8'd1, 1, 0}; // recover, rise
      vecs[6] = '{1'b1, 1'b1, 1'b0, 10, 1'b1, 1'b0, 1'b1, 8'd2, 0, 0}; // fault 2
      vecs[7] = '{1'b1, 1'b0, 1'b0,  8, 1'b1, 1'b1, 1'b1, 8'd2, 0, 0}; // same level
      vecs[8] = '{1'b0, 1'b1, 1'b1,  8, 1'b0, 1'b1, 1'b0, 8'd0, 0, 1}; // clear, fall
      vecs[9] = '{1'b0, 1'b1, 1'b0,  4, 1'b0, 1'b1, 1'b0, 8'd0, 0, 0};

      // ---------------- reset state ----------------
      reset     = 1'b0;
      clr_fault = 1'b0;
      drive(1'b0, 1'b1);
      #1 reset = 1'b1;
      #1 check_reset_outputs("reset");

      // ---------------- acquisition after reset ----------------
      @(negedge clk) reset = 1'b0;
      clear_strobe_counts();
      repeat (6) tick();
      check("acq_valid", valid, 1);
      check("acq_data", data_out, 0);
      check("acq_strobes", n_rise + n_fall, 0);
      check("acq_fault", fault, 0);

      // ---------------- exact rise latency ----------------
      drive(1'b1, 1'b0);
      repeat (5) tick();
      check("rise_e5_data", data_out, 0);
      check("rise_e5_rise", rise, 0);
      tick();
      check("rise_e6_data", data_out, 1);
      check("rise_e6_rise", rise, 1);
      check("rise_e6_fall", fall, 0);
      tick();
      check("rise_e7_rise", rise, 0);
      check("rise_e7_data", data_out, 1);

      // ---------------- exact fall latency ----------------
      drive(1'b0, 1'b1);
      repeat (5) tick();
      check("fall_e5_data", data_out, 1);
      tick();
      check("fall_e6_data", data_out, 0);
      check("fall_e6_fall", fall, 1);
      check("fall_e6_rise", rise, 0);
      tick();
      check("fall_e7_fall", fall, 0);
      repeat (3) tick();

      // ---------------- table-driven phases ----------------
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].o, vecs[i].ob);
         clr_fault = vecs[i].clr;
         clear_strobe_counts();
         repeat (vecs[i].ncyc) tick();
         check($sformatf("vec%0d_data", i),  data_out,    vecs[i].exp_data);
         check($sformatf("vec%0d_valid", i), valid,       vecs[i].exp_valid);
         check($sformatf("vec%0d_fault", i), fault,       vecs[i].exp_fault);
         check($sformatf("vec%0d_count", i), fault_count, vecs[i].exp_count);
         check($sformatf("vec%0d_rises", i), n_rise,      vecs[i].exp_rise);
         check($sformatf("vec%0d_falls", i), n_fall,      vecs[i].exp_fall);
      end
      clr_fault = 1'b0;

      // ---------------- clear coincides with fault entry ----------------
      drive(1'b0, 1'b0);
      repeat (5) tick();
      check("clrhit_e5_valid", valid, 1);
      clr_fault = 1'b1;
      tick();
      clr_fault = 1'b0;
      check("clrhit_e6_valid", valid, 0);
      check("clrhit_e6_fault", fault, 0);
      check("clrhit_e6_count", fault_count, 0);
      repeat (4) tick();
      check("clrhit_stay_fault", fault, 0);
      check("clrhit_stay_count", fault_count, 0);

      // Recovery at the held level: no strobe.
      drive(1'b0, 1'b1);
      clear_strobe_counts();
      repeat (8) tick();
      check("clrhit_rec_valid", valid, 1);
      check("clrhit_rec_strobes", n_rise + n_fall, 0);

      // ---------------- counter saturation ----------------
      for (int ep = 0; ep < 256; ep++) begin
         drive(1'b0, 1'b0);
         repeat (6) tick();
         drive(1'b0, 1'b1);
         repeat (6) tick();
         if (ep == 254) check("sat_count_255", fault_count, 255);
      end
      check("sat_count_256", fault_count, 255);
      check("sat_fault", fault, 1);
      check("sat_valid", valid, 1);

      // ---------------- reset mid-transition (cnt = 2) ----------------
      drive(1'b1, 1'b0);
      repeat (4) tick();
      #2 reset = 1'b1;
      #1 check_reset_outputs("midrst");
      drive(1'b0, 1'b1);
      @(negedge clk) reset = 1'b0;
      clear_strobe_counts();
      repeat (6) tick();
      check("reacq_valid", valid, 1);
      check("reacq_data", data_out, 0);
      check("reacq_strobes", n_rise + n_fall, 0);
      drive(1'b1, 1'b0);
      repeat (6) tick();
      check("reacq_rise_data", data_out, 1);
      check("reacq_rise_pulse", n_rise, 1);

      check("rise_fall_exclusive", n_both, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
